// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer.
// Holds the FSM state encoding, LFSR seed/taps with its step function,
// and the width of all millisecond quantities.
package reaction_pkg;

  localparam int unsigned TIME_W = 16;
  localparam int unsigned LFSR_W = 16;

  // Fibonacci taps 16,14,13,11 map to register bits 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_GO   = 3'd2,
    ST_DONE = 3'd3,
    ST_FOUL = 3'd4
  } state_e;

  // One shift step: feedback is the XOR of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_timer_fsm_if.sv
// Player/display side signals of the reaction timer.
//   start, press  : single-cycle request pulses into the timer
//   led_go        : GO indicator
//   current_time  : last valid reaction time in ms
//   update        : one-cycle strobe when current_time changes
//   foul, timeout : round-outcome flags
//   state         : raw FSM encoding for display logic
// master drives the pulses, slave is the timer.
interface reaction_timer_fsm_if;
  import reaction_pkg::*;

  logic              start;
  logic              press;
  logic              led_go;
  logic [TIME_W-1:0] current_time;
  logic              update;
  logic              foul;
  logic              timeout;
  logic [2:0]        state;

  modport master (
    output start, press,
    input  led_go, current_time, update, foul, timeout, state
  );

  modport slave (
    input  start, press,
    output led_go, current_time, update, foul, timeout, state
  );

endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   clr   : restart the count; the first tick then lands DIV cycles later
//   tick  : one-cycle pulse every DIV cycles
module ms_tick_gen #(
  parameter int unsigned DIV = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Tick is registered off the terminal count, so it appears in cycle DIV.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/reaction_timer_fsm.sv
// Reaction timer: random wait, GO light, millisecond reaction measurement.
//   clk   : system clock (rising edge)
//   rst_n : synchronous active-low reset; aborts any round without update
//   bus   : reaction_timer_fsm_if.slave (start/press in, results out)
// Optional feature macro FALSE_START_PENALTY_EN: a press during WAIT sends
// the round to FOUL. Without it such presses are ignored and foul stays 0.
module reaction_timer_fsm
  import reaction_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned TIMEOUT_MS   = 9999
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reaction_timer_fsm_if.slave  bus
);

  localparam int unsigned       TICK_DIV     = CLK_HZ / 1000;
  localparam logic [TIME_W-1:0] MIN_DELAY    = TIME_W'(MIN_DELAY_MS);
  localparam logic [TIME_W-1:0] TIMEOUT_LAST = TIME_W'(TIMEOUT_MS - 1);

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [TIME_W-1:0]   delay_q, delay_d;
  logic [TIME_W-1:0]   ms_q, ms_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic                update_q, update_d;
  logic                led_go_q, led_go_d;
  logic                foul_q, foul_d;
  logic                timeout_q, timeout_d;
  logic                tick;
  logic                clr_c;
  logic                false_start_c;

`ifdef FALSE_START_PENALTY_EN
  assign false_start_c = bus.press;
`else
  assign false_start_c = 1'b0;
`endif

  ms_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_c),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; unknown encodings fall back to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = bus.start ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        // A false start wins over a delay that expires in the same cycle.
        if (false_start_c)                          state_d = ST_FOUL;
        else if (tick && (delay_q <= TIME_W'(1)))   state_d = ST_GO;
        else                                        state_d = ST_WAIT;
      end
      ST_GO: begin
        if (bus.press)                              state_d = ST_DONE;
        else if (tick && (ms_q == TIMEOUT_LAST))    state_d = ST_DONE;
        else                                        state_d = ST_GO;
      end
      ST_DONE: state_d = bus.start ? ST_WAIT : ST_DONE;
      ST_FOUL: state_d = bus.start ? ST_WAIT : ST_FOUL;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and next output values.
  always_comb begin
    delay_d   = delay_q;
    ms_d      = ms_q;
    time_d    = time_q;
    update_d  = 1'b0;
    clr_c     = 1'b0;
    led_go_d  = (state_d == ST_GO);
    timeout_d = 1'b0;
`ifdef FALSE_START_PENALTY_EN
    foul_d    = (state_d == ST_FOUL);
`else
    foul_d    = 1'b0;
`endif

    if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) begin
      delay_d = MIN_DELAY + TIME_W'(lfsr_q[10:0]);
      clr_c   = 1'b1;
    end else if ((state_q == ST_WAIT) && tick) begin
      delay_d = delay_q - TIME_W'(1);
    end

    if ((state_d == ST_GO) && (state_q != ST_GO)) begin
      ms_d  = '0;
      clr_c = 1'b1;
    end else if ((state_q == ST_GO) && tick) begin
      ms_d = ms_q + TIME_W'(1);
    end

    // ms_q is the pre-increment value even when a tick coincides with press.
    if ((state_q == ST_GO) && bus.press) begin
      time_d   = ms_q;
      update_d = 1'b1;
    end

    // Set on the GO->DONE timeout exit, held while DONE persists.
    if (state_d == ST_DONE) begin
      if (state_q == ST_GO)        timeout_d = !bus.press;
      else if (state_q == ST_DONE) timeout_d = timeout_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q    <= LFSR_SEED;
      delay_q   <= '0;
      ms_q      <= '0;
      time_q    <= '1;
      update_q  <= 1'b0;
      led_go_q  <= 1'b0;
      foul_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_next(lfsr_q);
      delay_q   <= delay_d;
      ms_q      <= ms_d;
      time_q    <= time_d;
      update_q  <= update_d;
      led_go_q  <= led_go_d;
      foul_q    <= foul_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.led_go       = led_go_q;
  assign bus.current_time = time_q;
  assign bus.update       = update_q;
  assign bus.foul         = foul_q;
  assign bus.timeout      = timeout_q;

endmodule
